// File: rtl/led_shift_out_pkg.sv
// led_shift_out_pkg: state encoding and frame-length helper shared by the shifter and its bench
package led_shift_out_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT_LO = 2'd1,
        SHIFT_HI = 2'd2,
        LATCH    = 2'd3
    } state_t;

    // Cycles out_busy stays high for one frame: WIDTH low/high sclk pairs plus the latch phase.
    function automatic int frame_cycles(input int width, input int clk_div);
        return (2 * width + 1) * clk_div;
    endfunction

endpackage

// File: rtl/led_shift_tick.sv
// led_shift_tick: CLK_DIV phase divider for the LED shifter
// Ports:
//   clock          system clock
//   restart        forces the divider back to count 0 (frame start or reset)
//   phase_end      high in the last cycle of a CLK_DIV-cycle phase
//   phase_end_next value phase_end will take in the next cycle
module led_shift_tick #(
    parameter int CLK_DIV = 4
) (
    input  logic clock,
    input  logic restart,
    output logic phase_end,
    output logic phase_end_next
);

    localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] cnt;
    logic [DW-1:0] cnt_n;

    assign cnt_n          = (restart || cnt == LAST) ? '0 : cnt + 1'b1;
    assign phase_end_next = cnt_n == LAST;

    // phase_end is registered alongside cnt so it always equals (cnt == LAST).
    always_ff @(posedge clock) begin
        cnt       <= cnt_n;
        phase_end <= phase_end_next;
    end

endmodule

// File: rtl/led_shift_out.sv
// led_shift_out: streams the LED word to a 74HC595-style chain whenever it changes or a resend is forced
// Ports:
//   clock, reset    system clock, synchronous active-high reset
//   in_leds         LED word from the core
//   in_force        one-cycle request to resend the current word
//   out_sclk        serial clock, chain samples on its rising edge
//   out_sdata       serial data
//   out_latch       storage-register latch, active high
//   out_busy        high while a frame is in progress
//   out_frame_done  one-cycle pulse on the final latch cycle
module led_shift_out
    import led_shift_out_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int CLK_DIV   = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_leds,
    input  logic             in_force,
    output logic             out_sclk,
    output logic             out_sdata,
    output logic             out_latch,
    output logic             out_busy,
    output logic             out_frame_done
);

    localparam int BW = $clog2(WIDTH + 1);

    state_t           state;
    state_t           state_n;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_n;
    logic [WIDTH-1:0] last_sent;
    logic [BW-1:0]    bits;
    logic [BW-1:0]    bits_n;
    logic             start;
    logic             phase_end;
    logic             phase_end_next;
    logic             bit_n;

    assign start = state == IDLE && (in_leds != last_sent || in_force);

    led_shift_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clock          (clock),
        .restart        (reset || start),
        .phase_end      (phase_end),
        .phase_end_next (phase_end_next)
    );

    always_comb begin
        state_n = state;
        shreg_n = shreg;
        bits_n  = bits;
        case (state)
            IDLE: if (start) begin
                state_n = SHIFT_LO;
                shreg_n = in_leds;
                bits_n  = '0;
            end
            SHIFT_LO: if (phase_end) state_n = SHIFT_HI;
            SHIFT_HI: if (phase_end) begin
                shreg_n = MSB_FIRST ? shreg << 1 : shreg >> 1;
                bits_n  = bits + 1'b1;
                state_n = bits == BW'(WIDTH - 1) ? LATCH : SHIFT_LO;
            end
            default: if (phase_end) state_n = IDLE;
        endcase
        bit_n = MSB_FIRST ? shreg_n[WIDTH-1] : shreg_n[0];
    end

    // Outputs are decoded from the next state and registered, so the pins never glitch
    // and nothing reaches them combinationally from in_leds or in_force.
    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            shreg          <= '0;
            last_sent      <= '0;
            bits           <= '0;
            out_sclk       <= 1'b0;
            out_sdata      <= 1'b0;
            out_latch      <= 1'b0;
            out_busy       <= 1'b0;
            out_frame_done <= 1'b0;
        end else begin
            state          <= state_n;
            shreg          <= shreg_n;
            bits           <= bits_n;
            if (start) last_sent <= in_leds;
            out_sclk       <= state_n == SHIFT_HI;
            out_sdata      <= (state_n == SHIFT_LO || state_n == SHIFT_HI) && bit_n;
            out_latch      <= state_n == LATCH;
            out_busy       <= state_n != IDLE;
            out_frame_done <= state_n == LATCH && phase_end_next;
        end
    end

endmodule

// File: tb/tb_led_shift_out.sv
// tb_led_shift_out: randomized and directed checks of led_shift_out against a frame-level reference model
module tb_led_shift_out;
    import led_shift_out_pkg::*;

    localparam int F0 = frame_cycles(8, 2);
    localparam int F1 = frame_cycles(8, 1);

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       frc0 = 1'b0;
    logic       frc1 = 1'b0;
    logic [7:0] leds0 = 8'h00;
    logic [7:0] leds1 = 8'h00;
    logic       sclk0, sdata0, latch0, busy0, done0;
    logic       sclk1, sdata1, latch1, busy1, done1;

    int checks = 0;
    int passes = 0;

    always #5 clock = ~clock;

    led_shift_out #(.WIDTH(8), .CLK_DIV(2), .MSB_FIRST(1'b1)) dut0 (
        .clock(clock), .reset(reset), .in_leds(leds0), .in_force(frc0),
        .out_sclk(sclk0), .out_sdata(sdata0), .out_latch(latch0),
        .out_busy(busy0), .out_frame_done(done0)
    );

    led_shift_out #(.WIDTH(8), .CLK_DIV(1), .MSB_FIRST(1'b0)) dut1 (
        .clock(clock), .reset(reset), .in_leds(leds1), .in_force(frc1),
        .out_sclk(sclk1), .out_sdata(sdata1), .out_latch(latch1),
        .out_busy(busy1), .out_frame_done(done1)
    );

    // Reference model: a frame occupies F0 cycles; when idle, a changed word or a force starts one.
    int         m_left = 0;
    logic [7:0] m_last = 8'h00;
    logic [7:0] exp_q[$];

    always @(posedge clock) begin
        if (reset) begin
            m_left = 0;
            m_last = 8'h00;
        end else if (m_left == 0) begin
            if (leds0 != m_last || frc0) begin
                exp_q.push_back(leds0);
                m_last = leds0;
                m_left = F0;
            end
        end else begin
            m_left--;
        end
    end

    // Monitor: reassemble frames as the external shift register would see them.
    logic [7:0] acc = 8'h00;
    logic       prev_sclk = 1'b0;
    int         nb = 0, lc = 0, run = 0;
    int         busy_err = 0, bad_frames = 0, rises = 0, busy_cycles = 0;
    logic [7:0] rx_q[$];
    int         len_q[$];

    always @(negedge clock) begin
        if (busy0 !== (m_left > 0)) busy_err++;
        if (busy0) busy_cycles++;
        if (sclk0 && !prev_sclk) begin
            rises++;
            acc = {acc[6:0], sdata0};
            nb++;
        end
        if (latch0) lc++;
        if (done0) begin
            rx_q.push_back(acc);
            if (nb != 8 || lc != 2 || !latch0 || !busy0) bad_frames++;
            acc = 8'h00;
            nb = 0;
            lc = 0;
        end
        if (busy0) run++;
        else if (run != 0) begin
            len_q.push_back(run);
            run = 0;
        end
        prev_sclk = sclk0;
        if (reset) begin
            acc = 8'h00;
            nb = 0;
            lc = 0;
            run = 0;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic clear_mon();
        exp_q.delete();
        rx_q.delete();
        len_q.delete();
        busy_err = 0;
        bad_frames = 0;
        rises = 0;
        busy_cycles = 0;
    endtask

    task automatic do_reset();
        tick(1);
        reset = 1'b1;
        tick(2);
        clear_mon();
        reset = 1'b0;
    endtask

    task automatic wait_rx(input int n, input int budget, output bit ok);
        for (int i = 0; i < budget && rx_q.size() < n; i++) tick(1);
        ok = rx_q.size() >= n;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(3);
        @(negedge clock);
        checks++; if ({busy0, sclk0, sdata0, latch0, done0} !== 5'b0) $display("FAIL reset_outs0: got %b want 00000", {busy0, sclk0, sdata0, latch0, done0}); else passes++;
        checks++; if ({busy1, sclk1, sdata1, latch1, done1} !== 5'b0) $display("FAIL reset_outs1: got %b want 00000", {busy1, sclk1, sdata1, latch1, done1}); else passes++;
        tick(1);
        clear_mon();
        reset = 1'b0;
        tick(20);
        checks++; if (busy_cycles !== 0) $display("FAIL zero_word_busy: got %0d want 0", busy_cycles); else passes++;
        checks++; if (rises !== 0) $display("FAIL zero_word_sclk: got %0d want 0", rises); else passes++;
    endtask

    task automatic test_frame_timing();
        bit ok;
        leds0 = 8'hA5;
        wait_rx(1, 200, ok);
        tick(4);
        checks++; if (!ok) $display("FAIL timing_timeout: got %0d frames want 1", rx_q.size()); else passes++;
        checks++; if ((rx_q.size() == 1 ? rx_q[0] : 8'hxx) !== 8'hA5) $display("FAIL timing_word: got %h (%0d frames) want a5", rx_q.size() > 0 ? rx_q[0] : 8'hxx, rx_q.size()); else passes++;
        checks++; if ((len_q.size() == 1 ? len_q[0] : -1) !== F0) $display("FAIL timing_busy_len: got %0d want %0d", len_q.size() > 0 ? len_q[0] : -1, F0); else passes++;
        checks++; if (bad_frames !== 0) $display("FAIL timing_frame_shape: got %0d bad frames want 0", bad_frames); else passes++;
        checks++; if (busy_err !== 0) $display("FAIL timing_busy_model: got %0d mismatching cycles want 0", busy_err); else passes++;
    endtask

    task automatic test_unchanged();
        clear_mon();
        tick(200);
        checks++; if (rises !== 0) $display("FAIL unchanged_sclk: got %0d edges want 0", rises); else passes++;
        checks++; if (busy_cycles !== 0) $display("FAIL unchanged_busy: got %0d cycles want 0", busy_cycles); else passes++;
    endtask

    task automatic test_mid_frame();
        bit ok;
        do_reset();
        tick(6);
        leds0 = 8'h3C;
        tick(10);
        leds0 = 8'hFF;
        wait_rx(2, 300, ok);
        tick(60);
        checks++; if (!ok) $display("FAIL mid_timeout: got %0d frames want 2", rx_q.size()); else passes++;
        checks++; if (rx_q.size() !== 2) $display("FAIL mid_count: got %0d frames want 2", rx_q.size()); else passes++;
        checks++; if ((rx_q.size() > 0 ? rx_q[0] : 8'hxx) !== 8'hA5) $display("FAIL mid_first: got %h want a5", rx_q.size() > 0 ? rx_q[0] : 8'hxx); else passes++;
        checks++; if ((rx_q.size() > 1 ? rx_q[1] : 8'hxx) !== 8'hFF) $display("FAIL mid_second: got %h want ff", rx_q.size() > 1 ? rx_q[1] : 8'hxx); else passes++;
        checks++; if (rx_q != exp_q) $display("FAIL mid_model: got %0d frames, model %0d frames", rx_q.size(), exp_q.size()); else passes++;
        checks++; if (bad_frames + busy_err !== 0) $display("FAIL mid_shape: got %0d bad frames, %0d busy errors want 0", bad_frames, busy_err); else passes++;
    endtask

    task automatic test_force();
        bit ok;
        leds0 = 8'h00;
        do_reset();
        tick(3);
        frc0 = 1'b1;
        tick(1);
        frc0 = 1'b0;
        tick(5);
        frc0 = 1'b1;
        tick(1);
        frc0 = 1'b0;
        wait_rx(1, 200, ok);
        tick(80);
        checks++; if (!ok) $display("FAIL force_timeout: got %0d frames want 1", rx_q.size()); else passes++;
        checks++; if (rx_q.size() !== 1) $display("FAIL force_count: got %0d frames want 1", rx_q.size()); else passes++;
        checks++; if ((rx_q.size() > 0 ? rx_q[0] : 8'hxx) !== 8'h00) $display("FAIL force_word: got %h want 00", rx_q.size() > 0 ? rx_q[0] : 8'hxx); else passes++;
        checks++; if (rx_q != exp_q) $display("FAIL force_model: got %0d frames, model %0d frames", rx_q.size(), exp_q.size()); else passes++;
        checks++; if (bad_frames + busy_err !== 0) $display("FAIL force_shape: got %0d bad frames, %0d busy errors want 0", bad_frames, busy_err); else passes++;
    endtask

    task automatic test_reset_mid();
        bit ok;
        leds0 = 8'h81;
        do_reset();
        for (int i = 0; i < 200 && nb < 5; i++) tick(1);
        checks++; if (nb !== 5) $display("FAIL rstmid_reach: got %0d sclk edges want 5", nb); else passes++;
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        @(negedge clock);
        checks++; if ({busy0, sclk0, sdata0, latch0, done0} !== 5'b0) $display("FAIL rstmid_outs: got %b want 00000", {busy0, sclk0, sdata0, latch0, done0}); else passes++;
        clear_mon();
        wait_rx(1, 200, ok);
        tick(4);
        checks++; if (!ok) $display("FAIL rstmid_timeout: got %0d frames want 1", rx_q.size()); else passes++;
        checks++; if ((rx_q.size() == 1 ? rx_q[0] : 8'hxx) !== 8'h81) $display("FAIL rstmid_word: got %h (%0d frames) want 81", rx_q.size() > 0 ? rx_q[0] : 8'hxx, rx_q.size()); else passes++;
        checks++; if ((len_q.size() == 1 ? len_q[0] : -1) !== F0) $display("FAIL rstmid_len: got %0d want %0d", len_q.size() > 0 ? len_q[0] : -1, F0); else passes++;
        checks++; if (bad_frames + busy_err !== 0) $display("FAIL rstmid_shape: got %0d bad frames, %0d busy errors want 0", bad_frames, busy_err); else passes++;
    endtask

    task automatic test_random();
        int r;
        int diff;
        int bad_len;
        do_reset();
        for (int k = 0; k < 50; k++) begin
            tick($urandom_range(1, 60));
            r = $urandom_range(0, 3);
            if (r == 0) begin
                frc0 = 1'b1;
                tick(1);
                frc0 = 1'b0;
            end else if (r != 1) begin
                leds0 = 8'($urandom);
            end
        end
        for (int i = 0; i < 300 && (m_left != 0 || m_last != leds0); i++) tick(1);
        tick(4);
        diff = 0;
        for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) if (rx_q[i] !== exp_q[i]) diff++;
        bad_len = 0;
        foreach (len_q[i]) if (len_q[i] != F0) bad_len++;
        checks++; if (rx_q.size() !== exp_q.size()) $display("FAIL rand_count: got %0d frames want %0d", rx_q.size(), exp_q.size()); else passes++;
        checks++; if (diff !== 0) $display("FAIL rand_words: got %0d differing frames want 0", diff); else passes++;
        checks++; if (bad_len !== 0) $display("FAIL rand_len: got %0d frames of wrong length want 0", bad_len); else passes++;
        checks++; if (busy_err !== 0) $display("FAIL rand_busy: got %0d mismatching cycles want 0", busy_err); else passes++;
        checks++; if (bad_frames !== 0) $display("FAIL rand_shape: got %0d bad frames want 0", bad_frames); else passes++;
    endtask

    task automatic test_lsb_fast();
        logic [7:0] w;
        logic       first;
        logic       prev;
        int         nbit, bc, lcnt, dc;
        w = 8'h00;
        first = 1'b0;
        prev = 1'b0;
        nbit = 0;
        bc = 0;
        lcnt = 0;
        dc = 0;
        leds1 = 8'h01;
        repeat (40) begin
            @(negedge clock);
            if (sclk1 && !prev) begin
                if (nbit == 0) first = sdata1;
                w = {sdata1, w[7:1]};
                nbit++;
            end
            prev = sclk1;
            if (busy1) bc++;
            if (latch1) lcnt++;
            if (done1) dc++;
        end
        checks++; if (first !== 1'b1) $display("FAIL lsb_first_bit: got %b want 1", first); else passes++;
        checks++; if (w !== 8'h01) $display("FAIL lsb_word: got %h want 01", w); else passes++;
        checks++; if (nbit !== 8) $display("FAIL lsb_edges: got %0d want 8", nbit); else passes++;
        checks++; if (bc !== F1) $display("FAIL lsb_busy_len: got %0d want %0d", bc, F1); else passes++;
        checks++; if (lcnt !== 1) $display("FAIL lsb_latch_len: got %0d want 1", lcnt); else passes++;
        checks++; if (dc !== 1) $display("FAIL lsb_done: got %0d pulses want 1", dc); else passes++;
    endtask

    initial begin
        test_reset();
        test_frame_timing();
        test_unchanged();
        test_mid_frame();
        test_force();
        test_reset_mid();
        test_random();
        test_lsb_fast();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "timeout");
    end

endmodule
